// File: rtl/dw_pkg.sv
// Shared constants for the depthwise datapath: word geometry, burst widths and loader FSM codes.
package dw_pkg;

    localparam int unsigned DW_DATA_W = 128;
    localparam int unsigned DW_ADDR_W = 19;
    localparam int unsigned DW_CNT_W  = 11;
    localparam int unsigned DW_LANES  = 16;
    localparam int unsigned DW_K      = 3;
    localparam int unsigned DW_TAPS   = DW_K * DW_K;

    // One buffer word viewed as 16 byte-wide lanes.
    typedef logic [DW_LANES-1:0][7:0] lane_word_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ request lines; search starts at the registered pointer and wraps.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_req
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NREQ - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    assign any_req = |req;

    // Walk offsets from farthest to nearest so the nearest asserted line wins.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(ptr_q) + 32'(k)) % NREQ);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
        pick           = '0;
        pick[pick_idx] = any_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dw_burst_loader.sv
// Burst-read loader: arbitrates requesters, streams consecutive SRAM words back with
// per-requester grant/valid/done strobes. One burst outstanding at a time.
module dw_burst_loader
    import dw_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = DW_ADDR_W,
    parameter int unsigned CNT_W  = DW_CNT_W,
    parameter int unsigned DATA_W = DW_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] base_addr,
    input  logic [NREQ*CNT_W-1:0]  count,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        valid,
    output logic [DATA_W-1:0]      data,
    output logic [NREQ-1:0]        done,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, pick_idx;
    logic [NREQ-1:0]   pick, owner_oh, grant_q, valid_q;
    logic              any_req, accept, issue, zero_len;
    logic [ADDR_W-1:0] addr_q, base_sel;
    logic [CNT_W-1:0]  remaining_q, count_sel;
    logic [RD_LAT-1:0] busy_sr_q, busy_sr_d, beat_sr_q, beat_sr_d;
    logic [DATA_W-1:0] data_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .advance  (accept),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    assign accept = (state_q == ST_IDLE) && any_req;
    assign issue  = (state_q == ST_ISSUE);

    always_comb begin
        base_sel  = '0;
        count_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                base_sel  = base_addr[i*ADDR_W +: ADDR_W];
                count_sel = count[i*CNT_W +: CNT_W];
            end
        end
    end

    assign zero_len = (count_sel == '0);

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // A zero-length burst pushes a dataless occupancy marker into the pipe so its done
    // lands on the same RD_LAT-relative slot as a real burst would.
    always_comb begin
        busy_sr_d    = busy_sr_q << 1;
        busy_sr_d[0] = issue | (accept & zero_len);
        beat_sr_d    = beat_sr_q << 1;
        beat_sr_d[0] = issue;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = zero_len ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (busy_sr_q == '0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_sr_q   <= '0;
            beat_sr_q   <= '0;
            grant_q     <= '0;
            valid_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_sr_q <= busy_sr_d;
            beat_sr_q <= beat_sr_d;
            grant_q   <= accept ? pick : '0;
            valid_q   <= beat_sr_q[RD_LAT-1] ? owner_oh : '0;
            if (beat_sr_q[RD_LAT-1]) begin
                data_q <= mem_rdata;
            end
            if (accept) begin
                owner_q     <= pick_idx;
                addr_q      <= base_sel;
                remaining_q <= count_sel;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign grant    = grant_q;
    assign valid    = valid_q;
    assign data     = data_q;
    assign done     = (state_q == ST_FINISH) ? owner_oh : '0;
    assign mem_en   = issue;
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_dw_burst_loader.sv
// Self-checking bench: two loaders (RD_LAT=1 and RD_LAT=3) driven with directed and random
// bursts, compared cycle by cycle against a transaction-level timeline model.
module tb_dw_burst_loader;

    localparam int AW   = 19;
    localparam int CW   = 11;
    localparam int DW   = 128;
    localparam int MAXR = 512;
    localparam logic [DW-1:0] POISON = {4{32'hDEADBEEF}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]      req1 = '0, req3 = '0;
    logic [4*AW-1:0] base_addr = '0;
    logic [4*CW-1:0] count = '0;
    logic [3:0]      grant1, valid1, done1, grant3, valid3, done3;
    logic [DW-1:0]   data1, data3, rdata1, rdata3;
    logic            mem_en1, mem_en3;
    logic [AW-1:0]   mem_addr1, mem_addr3;
    logic [DW-1:0]   pipe3 [3];

    dw_burst_loader #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .base_addr(base_addr), .count(count),
        .grant(grant1), .valid(valid1), .data(data1), .done(done1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(rdata1)
    );

    dw_burst_loader #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .base_addr(base_addr), .count(count),
        .grant(grant3), .valid(valid3), .data(data3), .done(done3),
        .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(rdata3)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    // SRAM models: word n holds n, returned RD_LAT cycles after the enable.
    always @(posedge clk) rdata1 <= mem_en1 ? word(mem_addr1) : POISON;
    always @(posedge clk) begin
        pipe3[0] <= mem_en3 ? word(mem_addr3) : POISON;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata3 = pipe3[2];

    logic [3:0]    o_grant [2];
    logic [3:0]    o_valid [2];
    logic [3:0]    o_done  [2];
    logic          o_en    [2];
    logic [AW-1:0] o_addr  [2];
    logic [DW-1:0] o_data  [2];
    assign o_grant[0] = grant1;    assign o_grant[1] = grant3;
    assign o_valid[0] = valid1;    assign o_valid[1] = valid3;
    assign o_done[0]  = done1;     assign o_done[1]  = done3;
    assign o_en[0]    = mem_en1;   assign o_en[1]    = mem_en3;
    assign o_addr[0]  = mem_addr1; assign o_addr[1]  = mem_addr3;
    assign o_data[0]  = data1;     assign o_data[1]  = data3;

    logic [3:0]    e_grant [2][MAXR];
    logic [3:0]    e_valid [2][MAXR];
    logic [3:0]    e_done  [2][MAXR];
    logic          e_en    [2][MAXR];
    logic [AW-1:0] e_addr  [2][MAXR];
    logic [DW-1:0] e_data  [2][MAXR];

    int            mptr [2];
    logic [AW-1:0] base_v [4];
    logic [CW-1:0] cnt_v [4];
    int            beats [2];
    int            gseq0[$], gseq1[$];
    logic [AW-1:0] aseq0[$];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic set_inputs();
        for (int i = 0; i < 4; i++) begin
            base_addr[i*AW +: AW] = base_v[i];
            count[i*CW +: CW]     = cnt_v[i];
        end
    endtask

    // Timeline model: arbitration at t, grant t+1, issue t+1+i, beat t+lat+2+i,
    // done t+lat+2+count, next arbitration the cycle after done.
    task automatic model_build(input int inst, input logic [3:0] mask, input bit held,
                               input int hold_len, output int last);
        int t, w, d, lat;
        logic [3:0] granted, pend;
        logic [AW-1:0] a;
        lat = (inst == 0) ? 1 : 3;
        for (int r = 0; r < MAXR; r++) begin
            e_grant[inst][r] = '0; e_valid[inst][r] = '0; e_done[inst][r] = '0;
            e_en[inst][r] = 1'b0; e_addr[inst][r] = '0; e_data[inst][r] = '0;
        end
        t = 0; granted = '0; last = 0;
        while (t < MAXR - 64) begin
            pend = held ? ((t < hold_len) ? mask : 4'b0) : (mask & ~granted);
            if (pend == 4'b0) break;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (mptr[inst] + k) % 4;
                if (w < 0 && pend[c]) w = c;
            end
            e_grant[inst][t+1][w] = 1'b1;
            for (int i = 0; i < int'(cnt_v[w]); i++) begin
                a = base_v[w] + AW'(i);
                e_en[inst][t+1+i] = 1'b1;
                e_addr[inst][t+1+i] = a;
                e_valid[inst][t+lat+2+i][w] = 1'b1;
                e_data[inst][t+lat+2+i] = word(a);
            end
            d = t + lat + 2 + int'(cnt_v[w]);
            e_done[inst][d][w] = 1'b1;
            last = d;
            granted[w] = 1'b1;
            mptr[inst] = (w + 1) % 4;
            t = d + 1;
        end
    endtask

    task automatic run_bursts(input string name, input logic [3:0] mask, input bit held,
                              input int hold_len);
        int last0, last1, ncyc;
        logic [3:0] gprev1, gprev3;
        model_build(0, mask, held, hold_len, last0);
        model_build(1, mask, held, hold_len, last1);
        ncyc = ((last0 > last1) ? last0 : last1) + 4;
        beats[0] = 0; beats[1] = 0;
        gseq0.delete(); gseq1.delete(); aseq0.delete();
        gprev1 = '0; gprev3 = '0;
        for (int r = 0; r < ncyc; r++) begin
            @(posedge clk); #1;
            if (r == 0) begin
                set_inputs();
                req1 = mask; req3 = mask;
            end else if (held) begin
                req1 = (r < hold_len) ? mask : 4'b0;
                req3 = req1;
            end else begin
                req1 = req1 & ~gprev1;
                req3 = req3 & ~gprev3;
            end
            gprev1 = grant1; gprev3 = grant3;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({o_grant[i], o_valid[i], o_done[i], o_en[i]} !==
                    {e_grant[i][r], e_valid[i][r], e_done[i][r], e_en[i][r]}) begin
                    n_fail++;
                    $display("FAIL %s inst%0d cyc+%0d ctrl got g=%b v=%b d=%b en=%b want g=%b v=%b d=%b en=%b",
                             name, i, r, o_grant[i], o_valid[i], o_done[i], o_en[i],
                             e_grant[i][r], e_valid[i][r], e_done[i][r], e_en[i][r]);
                end
                if (e_en[i][r]) begin
                    n_checks++;
                    if (o_addr[i] !== e_addr[i][r]) begin
                        n_fail++;
                        $display("FAIL %s inst%0d cyc+%0d mem_addr got %h want %h",
                                 name, i, r, o_addr[i], e_addr[i][r]);
                    end
                end
                if (e_valid[i][r] != 4'b0) begin
                    n_checks++;
                    if (o_data[i] !== e_data[i][r]) begin
                        n_fail++;
                        $display("FAIL %s inst%0d cyc+%0d data got %h want %h",
                                 name, i, r, o_data[i], e_data[i][r]);
                    end
                end
                if (o_valid[i] != 4'b0) beats[i]++;
            end
            for (int k = 0; k < 4; k++) begin
                if (grant1[k]) gseq0.push_back(k);
                if (grant3[k]) gseq1.push_back(k);
            end
            if (mem_en1) aseq0.push_back(mem_addr1);
        end
        req1 = '0; req3 = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin base_v[i] = '0; cnt_v[i] = '0; end
        mptr[0] = 0; mptr[1] = 0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({o_grant[i], o_valid[i], o_done[i], o_en[i], o_addr[i], o_data[i]} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_values inst%0d got g=%b v=%b d=%b en=%b addr=%h data=%h want all 0",
                             i, o_grant[i], o_valid[i], o_done[i], o_en[i], o_addr[i], o_data[i]);
                end
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_order [4] = '{0, 1, 3, 0};
        base_v[0] = 19'h01000; base_v[1] = 19'h02000; base_v[2] = 19'h03000; base_v[3] = 19'h04000;
        for (int i = 0; i < 4; i++) cnt_v[i] = 11'd2;
        run_bursts("round_robin", 4'b1011, 1'b1, 19);
        n_checks++;
        if (gseq0.size() != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count inst0 got %0d want 4", gseq0.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < gseq0.size()) begin
                n_checks++;
                if (gseq0[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order inst0 grant#%0d got %0d want %0d", i, gseq0[i], exp_order[i]);
                end
            end
            if (i < 3 && i < gseq1.size()) begin
                n_checks++;
                if (gseq1[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order inst1 grant#%0d got %0d want %0d", i, gseq1[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_single_burst();
        base_v[1] = 19'h00100; cnt_v[1] = 11'd9;
        run_bursts("single_burst", 4'b0010, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (beats[i] != 9) begin
                n_fail++;
                $display("FAIL single_beats inst%0d got %0d want 9", i, beats[i]);
            end
        end
    endtask

    task automatic test_count_zero();
        cnt_v[2] = 11'd0; base_v[2] = 19'h0ABCD;
        run_bursts("count_zero", 4'b0100, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (beats[i] != 0) begin
                n_fail++;
                $display("FAIL zero_beats inst%0d got %0d want 0", i, beats[i]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] exp_a [4] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
        base_v[3] = 19'h7FFFE; cnt_v[3] = 11'd4;
        run_bursts("addr_wrap", 4'b1000, 1'b0, 0);
        n_checks++;
        if (aseq0.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_issue_count got %0d want 4", aseq0.size());
        end
        for (int i = 0; i < 4 && i < aseq0.size(); i++) begin
            n_checks++;
            if (aseq0[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_addr#%0d got %h want %h", i, aseq0[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        bit held;
        int hold_len;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4; i++) begin
                base_v[i] = ($urandom_range(0, 3) == 0) ? 19'h7FFF8 + AW'($urandom_range(0, 7))
                                                        : AW'($urandom);
                cnt_v[i] = CW'($urandom_range(0, 12));
            end
            mask = 4'($urandom_range(1, 15));
            held = ($urandom_range(0, 3) == 0);
            hold_len = $urandom_range(1, 25);
            run_bursts("random", mask, held, hold_len);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        base_v[1] = 19'h00100; cnt_v[1] = 11'd9;
        @(posedge clk); #1;
        set_inputs();
        req1 = 4'b0010; req3 = 4'b0010;
        seen = 0;
        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            if (valid1 != 4'b0) seen++;
            if (seen == 4) break;
            @(posedge clk); #1;
            if (r >= 1) begin req1 = '0; req3 = '0; end
        end
        n_checks++;
        if (seen != 4) begin
            n_fail++;
            $display("FAIL midreset_beats_before got %0d want 4", seen);
        end
        req1 = '0; req3 = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        mptr[0] = 0; mptr[1] = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({o_grant[i], o_valid[i], o_done[i], o_en[i], o_addr[i], o_data[i]} !== '0) begin
                n_fail++;
                $display("FAIL midreset_immediate inst%0d got g=%b v=%b d=%b en=%b addr=%h data=%h want all 0",
                         i, o_grant[i], o_valid[i], o_done[i], o_en[i], o_addr[i], o_data[i]);
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({o_grant[i], o_valid[i], o_done[i], o_en[i]} !== '0) begin
                    n_fail++;
                    $display("FAIL midreset_quiet inst%0d cyc+%0d got g=%b v=%b d=%b en=%b want 0",
                             i, r, o_grant[i], o_valid[i], o_done[i], o_en[i]);
                end
            end
        end
        base_v[0] = 19'h00040; cnt_v[0] = 11'd3;
        base_v[3] = 19'h00200; cnt_v[3] = 11'd2;
        run_bursts("post_reset", 4'b1011, 1'b0, 0);
        n_checks++;
        if (gseq0.size() == 0 || gseq0[0] != 0) begin
            n_fail++;
            $display("FAIL post_reset_first_grant inst0 got %0d want 0",
                     (gseq0.size() == 0) ? -1 : gseq0[0]);
        end
        n_checks++;
        if (gseq1.size() == 0 || gseq1[0] != 0) begin
            n_fail++;
            $display("FAIL post_reset_first_grant inst1 got %0d want 0",
                     (gseq1.size() == 0) ? -1 : gseq1[0]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_burst();
        test_count_zero();
        test_addr_wrap();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
